// File: rtl/tc_pl_bus_poll.sv
// Autonomous poll sequencer for the PL SPI bus controller: every period it loads a
// chip-select header plus command bytes, triggers one frame, and assembles the reply.
module tc_pl_bus_poll #(
  parameter int            NB   = 2,
  parameter logic [7:0]    CSEL = 8'h01,
  parameter logic [31:0]   CMDW = 32'h0000_0000,
  parameter int            PW   = 16,
  parameter logic [PW-1:0] TMO  = {PW{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [PW-1:0]   period,
  input  logic [5:0]      bus_state,
  input  logic [7:0]      bus_rdata,
  output logic [8:0]      bus_wdata,
  output logic            bus_wr,
  output logic [1:0]      bus_trig,
  output logic            bus_clr,
  output logic            bus_rd,
  output logic [8*NB-1:0] smp_data,
  output logic            smp_valid,
  output logic            err_tmo,
  output logic            busy
);

  localparam int SW = 8 * NB;
  localparam int CW = 3;
  localparam logic [31:0] CMDL = CMDW << (8 * (4 - NB));

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_TRIG = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_READ = 3'd4;
  localparam logic [2:0] S_CLR  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tpend_q, tpend_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [31:0]   cmd_q, cmd_d;
  logic [PW-1:0] tcnt_q, tcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic          rd_q;
  logic [SW-1:0] sh_q, sh_d;
  logic [SW-1:0] smp_q, smp_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;

  logic [PW-1:0] pval;
  logic          tick;
  logic [PW-1:0] tcntInc;
  logic          tmoHit;
  logic [SW-1:0] shNext;
  logic          timeout;
  logic          unused_ok;

  assign unused_ok = ^{bus_state[5], bus_state[2], bus_state[0]};

  // Periods of 0 and 1 behave as 2 so a tick can never fire on consecutive cycles.
  assign pval    = (period < PW'(2)) ? PW'(2) : period;
  assign tick    = en && (pcnt_q >= pval - PW'(1));
  assign tcntInc = tcnt_q + PW'(1);
  assign tmoHit  = (tcntInc == TMO);
  assign shNext  = SW'({sh_q, bus_rdata});

  assign bus_wr    = (state_q == S_LOAD) && !bus_state[3];
  assign bus_wdata = (state_q != S_LOAD) ? 9'h000 :
                     (wcnt_q == '0)      ? {1'b1, CSEL} : {1'b0, cmd_q[31:24]};
  assign bus_trig  = {1'b0, state_q == S_TRIG};
  assign bus_clr   = (state_q == S_CLR);
  assign bus_rd    = (state_q == S_READ) && !bus_state[4] && (rcnt_q != CW'(NB));
  assign smp_data  = smp_q;
  assign smp_valid = (state_q == S_CLR) && ok_q;
  assign err_tmo   = err_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    tpend_d = tpend_q;
    wcnt_d  = wcnt_q;
    cmd_d   = cmd_q;
    tcnt_d  = tcnt_q;
    rcnt_d  = rcnt_q;
    ccnt_d  = ccnt_q;
    sh_d    = sh_q;
    smp_d   = smp_q;
    ok_d    = ok_q;
    timeout = 1'b0;
    pcnt_d  = (!en || tick) ? '0 : pcnt_q + PW'(1);

    // Ticks are only accepted while idle or clearing; during a frame they are dropped.
    if (!en)
      tpend_d = 1'b0;
    else if (tick && (state_q == S_IDLE || state_q == S_CLR))
      tpend_d = 1'b1;

    if (rd_q) begin
      sh_d   = shNext;
      ccnt_d = ccnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (en && tpend_q) begin
          state_d = S_LOAD;
          tpend_d = 1'b0;
          wcnt_d  = '0;
          cmd_d   = CMDL;
        end
      end
      S_LOAD: begin
        if (bus_wr) begin
          wcnt_d = wcnt_q + CW'(1);
          if (wcnt_q != '0) cmd_d = cmd_q << 8;
          if (wcnt_q == CW'(NB)) state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        tcnt_d  = '0;
        rcnt_d  = '0;
        ccnt_d  = '0;
        ok_d    = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus_state[1]) begin
          state_d = S_READ;
          tcnt_d  = '0;
        end else if (tmoHit) begin
          timeout = 1'b1;
          state_d = S_CLR;
        end else begin
          tcnt_d = tcntInc;
        end
      end
      S_READ: begin
        if (bus_rd) rcnt_d = rcnt_q + CW'(1);
        if (rd_q && ccnt_q == CW'(NB - 1)) begin
          ok_d    = 1'b1;
          smp_d   = shNext;
          state_d = S_CLR;
        end else if (tmoHit) begin
          timeout = 1'b1;
          state_d = S_CLR;
        end else begin
          tcnt_d = tcntInc;
        end
      end
      S_CLR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (!en)
      err_d = 1'b0;
    else if (timeout)
      err_d = 1'b1;
    else
      err_d = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pcnt_q  <= '0;
      tpend_q <= 1'b0;
      wcnt_q  <= '0;
      cmd_q   <= '0;
      tcnt_q  <= '0;
      rcnt_q  <= '0;
      ccnt_q  <= '0;
      rd_q    <= 1'b0;
      sh_q    <= '0;
      smp_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      tpend_q <= tpend_d;
      wcnt_q  <= wcnt_d;
      cmd_q   <= cmd_d;
      tcnt_q  <= tcnt_d;
      rcnt_q  <= rcnt_d;
      ccnt_q  <= ccnt_d;
      rd_q    <= bus_rd;
      sh_q    <= sh_d;
      smp_q   <= smp_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tc_pl_bus_poll.sv
// Self-checking bench for tc_pl_bus_poll with a behavioural SPI controller model and
// frame-level expectations derived from the header/command/sample rules.
module tb_tc_pl_bus_poll;

  localparam int          NB   = 2;
  localparam logic [7:0]  CSEL = 8'h01;
  localparam logic [31:0] CMDW = 32'h0000_A55A;
  localparam int          PW   = 16;
  localparam logic [15:0] TMO  = 16'd50;
  localparam int          SW   = 8 * NB;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [15:0]   period;
  logic [5:0]    bus_state;
  logic [7:0]    bus_rdata;
  logic [8:0]    bus_wdata;
  logic          bus_wr;
  logic [1:0]    bus_trig;
  logic          bus_clr;
  logic          bus_rd;
  logic [SW-1:0] smp_data;
  logic          smp_valid;
  logic          err_tmo;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  tc_pl_bus_poll #(.NB(NB), .CSEL(CSEL), .CMDW(CMDW), .PW(PW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period),
    .bus_state(bus_state), .bus_rdata(bus_rdata),
    .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_trig(bus_trig), .bus_clr(bus_clr),
    .bus_rd(bus_rd), .smp_data(smp_data), .smp_valid(smp_valid),
    .err_tmo(err_tmo), .busy(busy)
  );

  always #5 clk = ~clk;

  // Controller model state
  int         cmptDelay;
  int         cmptCnt;
  bit         armed;
  bit         cmpt;
  int         fullCnt;
  bit         stallOnHeader;
  logic [7:0] respQ[$];
  logic [7:0] rxq[$];
  logic [7:0] expBytes[$];

  bit         s_wr, s_trig, s_clr, s_rd;
  logic [8:0] s_wdata;

  // Event logs
  logic [8:0]    wrQ[$];
  int            wrCycQ[$];
  int            trigQ[$];
  int            clrQ[$];
  int            rdQ[$];
  int            startQ[$];
  logic [SW-1:0] smpQ[$];
  int            smpCycQ[$];
  bit            errClrQ[$];
  bit            errPreQ[$];
  int            holdCnt, wrFull, trig1Cnt;
  bit            prevBusy, prevErr;

  // Outputs are sampled on the falling edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    s_wr = bus_wr; s_trig = bus_trig[0]; s_clr = bus_clr; s_rd = bus_rd; s_wdata = bus_wdata;
    if (!rst) begin
      if (bus_wr) begin wrQ.push_back(bus_wdata); wrCycQ.push_back(cyc); end
      if (bus_trig[0]) trigQ.push_back(cyc);
      if (bus_trig[1]) trig1Cnt++;
      if (bus_clr) begin clrQ.push_back(cyc); errClrQ.push_back(err_tmo); errPreQ.push_back(prevErr); end
      if (bus_rd) rdQ.push_back(cyc);
      if (smp_valid) begin smpQ.push_back(smp_data); smpCycQ.push_back(cyc); end
      if (busy && !prevBusy) startQ.push_back(cyc);
      if (bus_state[3]) begin
        if (bus_wr) wrFull++;
        else if (busy && bus_wdata == 9'h0A5) holdCnt++;
      end
    end
    prevBusy = busy;
    prevErr  = err_tmo;
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst) begin
      if (fullCnt > 0) fullCnt--;
      if (s_wr && s_wdata[8] && stallOnHeader) begin fullCnt = 5; stallOnHeader = 0; end
      if (s_trig) begin
        armed = (cmptDelay >= 0);
        cmptCnt = cmptDelay;
      end else if (armed) begin
        if (cmptCnt > 0) cmptCnt--;
        if (cmptCnt == 0) begin
          armed = 0;
          cmpt = 1;
          for (int j = 0; j < NB; j++) if (respQ.size() > 0) rxq.push_back(respQ.pop_front());
        end
      end
      if (s_clr) cmpt = 0;
      if (s_rd && rxq.size() > 0) bus_rdata = rxq.pop_front();
      bus_state = {1'b0, rxq.size() == 0, fullCnt > 0, 1'b1, cmpt, 1'b0};
    end
  end

  function automatic logic [8:0] expWord(int k);
    logic [31:0] c;
    c = CMDW;
    if (k == 0) return {1'b1, CSEL};
    return {1'b0, 8'((c >> (8 * (NB - k))) & 32'hFF)};
  endfunction

  function automatic logic [SW-1:0] expSample(int f);
    logic [SW-1:0] s;
    s = '0;
    for (int j = 0; j < NB; j++) s = (s << 8) | SW'(expBytes[f * NB + j]);
    return s;
  endfunction

  task automatic resetModel();
    cmptDelay = 10; cmptCnt = 0; armed = 0; cmpt = 0; fullCnt = 0; stallOnHeader = 0;
    rxq.delete(); respQ.delete(); expBytes.delete();
    bus_rdata = 8'h00;
    bus_state = 6'b010100;
  endtask

  task automatic clearLogs();
    wrQ.delete(); wrCycQ.delete(); trigQ.delete(); clrQ.delete(); rdQ.delete();
    startQ.delete(); smpQ.delete(); smpCycQ.delete(); errClrQ.delete(); errPreQ.delete();
    holdCnt = 0; wrFull = 0; trig1Cnt = 0;
  endtask

  task automatic pushResp(input int frames);
    logic [7:0] b;
    for (int i = 0; i < frames * NB; i++) begin
      b = 8'($urandom);
      respQ.push_back(b);
      expBytes.push_back(b);
    end
  endtask

  task automatic waitClr(input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (clrQ.size() < n && t < budget) begin @(posedge clk); t++; end
    ok = (clrQ.size() >= n);
  endtask

  task automatic settle();
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; period = 16'd100;
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus_wr !== 1'b0 || bus_wdata !== 9'h000) begin errors++; $display("[TB] FAIL reset_wr: wr=%b wdata=%h expected 0/000", bus_wr, bus_wdata); end
    checks++; if (bus_trig !== 2'b00 || bus_clr !== 1'b0 || bus_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_ctl: trig=%b clr=%b rd=%b expected 0", bus_trig, bus_clr, bus_rd); end
    checks++; if (smp_data !== '0 || smp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_smp: data=%h valid=%b expected 0", smp_data, smp_valid); end
    checks++; if (err_tmo !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: err=%b busy=%b expected 0", err_tmo, busy); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic_frame();
    bit ok;
    resetModel(); clearLogs();
    cmptDelay = 40;
    expBytes.push_back(8'h12); expBytes.push_back(8'h34); expBytes.push_back(8'h56); expBytes.push_back(8'h78);
    respQ.push_back(8'h12); respQ.push_back(8'h34); respQ.push_back(8'h56); respQ.push_back(8'h78);
    period = 16'd100; en = 1'b1;
    waitClr(2, 500, ok);
    settle();
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_wait: clr count=%0d expected 2", clrQ.size()); return; end
    for (int i = 0; i < 3 && i < wrQ.size(); i++) begin
      checks++; if (wrQ[i] !== expWord(i)) begin errors++; $display("[TB] FAIL basic_word%0d: got %h expected %h", i, wrQ[i], expWord(i)); end
    end
    checks++; if (wrQ.size() != 6 || trigQ.size() != 2 || clrQ.size() != 2) begin errors++; $display("[TB] FAIL basic_counts: wr=%0d trig=%0d clr=%0d expected 6/2/2", wrQ.size(), trigQ.size(), clrQ.size()); end
    checks++; if (trig1Cnt != 0) begin errors++; $display("[TB] FAIL basic_trig1: got %0d expected 0", trig1Cnt); end
    checks++; if (smpQ.size() != 2 || smpQ[0] !== expSample(0) || smpQ[1] !== expSample(1)) begin errors++; $display("[TB] FAIL basic_sample: n=%0d s0=%h expected 2/%h", smpQ.size(), smpQ.size() > 0 ? smpQ[0] : '0, expSample(0)); end
    checks++; if (smpCycQ.size() != 2 || smpCycQ[0] != clrQ[0]) begin errors++; $display("[TB] FAIL basic_valid_cycle: n=%0d expected pulse in clr cycle %0d", smpCycQ.size(), clrQ[0]); end
    checks++; if (startQ.size() < 2 || startQ[1] - startQ[0] != 100) begin errors++; $display("[TB] FAIL basic_interval: got %0d expected 100", startQ.size() < 2 ? -1 : startQ[1] - startQ[0]); end
    checks++; if (trigQ[0] - startQ[0] != NB + 1) begin errors++; $display("[TB] FAIL basic_load_lat: got %0d expected %0d", trigQ[0] - startQ[0], NB + 1); end
    checks++; if (rdQ.size() < 1 || clrQ[0] - rdQ[0] != NB + 1) begin errors++; $display("[TB] FAIL basic_read_lat: got %0d expected %0d", rdQ.size() < 1 ? -1 : clrQ[0] - rdQ[0], NB + 1); end
    checks++; if (smp_data !== expSample(1)) begin errors++; $display("[TB] FAIL basic_hold: smp_data=%h expected %h", smp_data, expSample(1)); end
  endtask

  task automatic test_tx_full();
    bit ok;
    resetModel(); clearLogs();
    cmptDelay = 15; stallOnHeader = 1; pushResp(1);
    period = 16'd120; en = 1'b1;
    waitClr(1, 400, ok);
    settle();
    checks++; if (!ok) begin errors++; $display("[TB] FAIL full_wait: clr count=%0d expected 1", clrQ.size()); return; end
    checks++; if (wrQ.size() != 3) begin errors++; $display("[TB] FAIL full_nwr: got %0d expected 3", wrQ.size()); end
    for (int i = 0; i < 3 && i < wrQ.size(); i++) begin
      checks++; if (wrQ[i] !== expWord(i)) begin errors++; $display("[TB] FAIL full_word%0d: got %h expected %h", i, wrQ[i], expWord(i)); end
    end
    checks++; if (holdCnt != 5 || wrFull != 0) begin errors++; $display("[TB] FAIL full_hold: held=%0d wr_while_full=%0d expected 5/0", holdCnt, wrFull); end
    checks++; if (wrCycQ.size() < 2 || wrCycQ[1] - wrCycQ[0] != 6) begin errors++; $display("[TB] FAIL full_gap: got %0d expected 6", wrCycQ.size() < 2 ? -1 : wrCycQ[1] - wrCycQ[0]); end
    checks++; if (smpQ.size() != 1 || smpQ[0] !== expSample(0)) begin errors++; $display("[TB] FAIL full_sample: n=%0d expected 1 sample %h", smpQ.size(), expSample(0)); end
  endtask

  task automatic test_timeout();
    bit ok;
    resetModel(); clearLogs();
    cmptDelay = -1;
    period = 16'd200; en = 1'b1;
    waitClr(1, 500, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL tmo_wait: clr count=%0d expected 1", clrQ.size()); settle(); return; end
    checks++; if (clrQ[0] - trigQ[0] != int'(TMO) + 1) begin errors++; $display("[TB] FAIL tmo_length: got %0d expected %0d", clrQ[0] - trigQ[0], int'(TMO) + 1); end
    checks++; if (errClrQ[0] !== 1'b1 || errPreQ[0] !== 1'b0) begin errors++; $display("[TB] FAIL tmo_err_edge: at_clr=%b before=%b expected 1/0", errClrQ[0], errPreQ[0]); end
    checks++; if (rdQ.size() != 0 || smpQ.size() != 0) begin errors++; $display("[TB] FAIL tmo_no_read: rd=%0d smp=%0d expected 0/0", rdQ.size(), smpQ.size()); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (err_tmo !== 1'b1) begin errors++; $display("[TB] FAIL tmo_sticky: got %b expected 1", err_tmo); end
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err_tmo !== 1'b0) begin errors++; $display("[TB] FAIL tmo_clear: got %b expected 0", err_tmo); end
    settle();
  endtask

  task automatic test_en_drop();
    int t;
    bit ok;
    resetModel(); clearLogs();
    cmptDelay = 20; pushResp(1);
    period = 16'd100; en = 1'b1;
    t = 0;
    while (startQ.size() == 0 && t < 300) begin @(posedge clk); t++; end
    #1;
    en = 1'b0;
    checks++; if (startQ.size() == 0) begin errors++; $display("[TB] FAIL drop_start: no frame within %0d cycles", t); return; end
    waitClr(1, 300, ok);
    repeat (300) @(posedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL drop_wait: clr count=%0d expected 1", clrQ.size()); end
    checks++; if (wrQ.size() != NB + 1 || trigQ.size() != 1 || rdQ.size() != NB || clrQ.size() != 1) begin errors++; $display("[TB] FAIL drop_counts: wr=%0d trig=%0d rd=%0d clr=%0d expected 3/1/2/1", wrQ.size(), trigQ.size(), rdQ.size(), clrQ.size()); end
    checks++; if (startQ.size() != 1) begin errors++; $display("[TB] FAIL drop_frames: got %0d expected 1", startQ.size()); end
    checks++; if (smpQ.size() != 1 || smpQ[0] !== expSample(0)) begin errors++; $display("[TB] FAIL drop_sample: n=%0d expected 1 sample %h", smpQ.size(), expSample(0)); end
    checks++; if (err_tmo !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_flags: err=%b busy=%b expected 0/0", err_tmo, busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n, t, gap;
    resetModel(); clearLogs();
    cmptDelay = int'($urandom_range(2, 8)); pushResp(10);
    period = 16'd0; en = 1'b1;
    waitClr(6, 600, ok);
    en = 1'b0;
    t = 0;
    while (busy && t < 200) begin @(posedge clk); t++; end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (!ok || busy) begin errors++; $display("[TB] FAIL b2b_wait: clr=%0d busy=%b expected >=6/0", clrQ.size(), busy); return; end
    n = clrQ.size();
    checks++; if (trigQ.size() != n || startQ.size() != n || smpQ.size() != n) begin errors++; $display("[TB] FAIL b2b_counts: trig=%0d start=%0d smp=%0d expected %0d", trigQ.size(), startQ.size(), smpQ.size(), n); end
    checks++; if (wrQ.size() != n * (NB + 1) || rdQ.size() != n * NB) begin errors++; $display("[TB] FAIL b2b_bus: wr=%0d rd=%0d expected %0d/%0d", wrQ.size(), rdQ.size(), n * (NB + 1), n * NB); end
    for (int i = 0; i < n && i < smpQ.size(); i++) begin
      checks++; if (smpQ[i] !== expSample(i)) begin errors++; $display("[TB] FAIL b2b_sample%0d: got %h expected %h", i, smpQ[i], expSample(i)); end
    end
    for (int i = 0; i + 1 < n && i + 1 < startQ.size(); i++) begin
      gap = startQ[i + 1] - clrQ[i];
      checks++; if (gap < 2 || gap > 3 || trigQ[i] <= startQ[i] || clrQ[i] <= trigQ[i]) begin errors++; $display("[TB] FAIL b2b_order%0d: restart gap=%0d expected 2..3", i, gap); end
    end
  endtask

  task automatic test_random_frames();
    bit ok;
    int p;
    for (int it = 0; it < 4; it++) begin
      resetModel(); clearLogs();
      cmptDelay = int'($urandom_range(5, 40));
      p = int'($urandom_range(60, 150));
      pushResp(2);
      period = 16'(p); en = 1'b1;
      waitClr(2, 2 * p + 300, ok);
      settle();
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rand%0d_wait: clr=%0d expected 2", it, clrQ.size()); continue; end
      for (int i = 0; i < 6 && i < wrQ.size(); i++) begin
        checks++; if (wrQ[i] !== expWord(i % 3)) begin errors++; $display("[TB] FAIL rand%0d_word%0d: got %h expected %h", it, i, wrQ[i], expWord(i % 3)); end
      end
      checks++; if (smpQ.size() != 2 || smpQ[0] !== expSample(0) || smpQ[1] !== expSample(1)) begin errors++; $display("[TB] FAIL rand%0d_sample: n=%0d expected %h,%h", it, smpQ.size(), expSample(0), expSample(1)); end
      checks++; if (startQ.size() < 2 || startQ[1] - startQ[0] != p) begin errors++; $display("[TB] FAIL rand%0d_interval: got %0d expected %0d", it, startQ.size() < 2 ? -1 : startQ[1] - startQ[0], p); end
    end
  endtask

  task automatic test_async_reset();
    int t;
    bit ok;
    resetModel(); clearLogs();
    cmptDelay = 10; pushResp(1);
    period = 16'd30; en = 1'b1;
    t = 0;
    while (rdQ.size() == 0 && t < 200) begin @(posedge clk); t++; end
    checks++; if (rdQ.size() == 0) begin errors++; $display("[TB] FAIL arst_read: no read within %0d cycles", t); settle(); return; end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || bus_rd !== 1'b0 || bus_clr !== 1'b0 || bus_trig !== 2'b00) begin errors++; $display("[TB] FAIL arst_ctl: busy=%b rd=%b clr=%b trig=%b expected 0", busy, bus_rd, bus_clr, bus_trig); end
    checks++; if (bus_wr !== 1'b0 || bus_wdata !== 9'h000 || smp_data !== '0 || smp_valid !== 1'b0 || err_tmo !== 1'b0) begin errors++; $display("[TB] FAIL arst_data: wr=%b wdata=%h smp=%h valid=%b err=%b expected 0", bus_wr, bus_wdata, smp_data, smp_valid, err_tmo); end
    en = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearLogs();
    cmptDelay = 12; pushResp(1);
    @(posedge clk);
    #1;
    en = 1'b1;
    waitClr(1, 200, ok);
    settle();
    checks++; if (!ok) begin errors++; $display("[TB] FAIL arst_wait: clr=%0d expected 1", clrQ.size()); return; end
    checks++; if (wrQ.size() != 3 || wrQ[0] !== expWord(0) || wrQ[1] !== expWord(1) || wrQ[2] !== expWord(2)) begin errors++; $display("[TB] FAIL arst_words: n=%0d expected 3 words %h %h %h", wrQ.size(), expWord(0), expWord(1), expWord(2)); end
    checks++; if (smpQ.size() != 1 || smpQ[0] !== expSample(0)) begin errors++; $display("[TB] FAIL arst_sample: n=%0d expected 1 sample %h", smpQ.size(), expSample(0)); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; period = 16'd100;
    bus_state = 6'b010100; bus_rdata = 8'h00;
    test_reset();
    test_basic_frame();
    test_tx_full();
    test_timeout();
    test_en_drop();
    test_back_to_back();
    test_random_frames();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
